// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt controller: FSM states,
// ICTRL field positions and the default register addresses.
package irq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } irq_state_e;

  localparam int ICTRL_GIE    = 0;
  localparam int ICTRL_BUSY   = 1;
  localparam int ICTRL_ID_LSB = 8;
  localparam int ICTRL_ID_MSB = 11;
  localparam int ID_W         = ICTRL_ID_MSB - ICTRL_ID_LSB + 1;

  localparam logic [31:0] DEF_IPEND_BASE = 32'hF000_0100;
  localparam logic [31:0] DEF_IMASK_BASE = 32'hF000_0104;
  localparam logic [31:0] DEF_ICTRL_BASE = 32'hF000_0108;

endpackage

// File: rtl/Register.sv
// Generic enable-load register with synchronous active-high reset to zero.
module Register #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_q;

  // next value: load new data or hold
  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = d;
    end else begin
      q_d = q_q;
    end
  end

  // storage flop
  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= {WIDTH{1'b0}};
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: index of the lowest set request bit plus a valid flag.
module irq_prio_enc #(
  parameter int NSRC = 4,
  parameter int ID_W = 4
) (
  input  logic [NSRC-1:0] req,
  output logic            valid,
  output logic [ID_W-1:0] idx
);

  // scan from the top down so the lowest set bit is the last one to land
  always_comb begin
    valid = 1'b0;
    idx   = {ID_W{1'b0}};
    for (int i = NSRC - 1; i >= 0; i--) begin
      idx   = req[i] ? ID_W'(i) : idx;
      valid = valid | req[i];
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Memory-mapped interrupt controller: latches rising edges on the device lines,
// masks and prioritises them, and runs a req/ack/done handshake with the CPU.
module irq_controller
  import irq_pkg::*;
#(
  parameter int              BITS       = 32,
  parameter int              NSRC       = 4,
  parameter logic [BITS-1:0] IPEND_BASE = DEF_IPEND_BASE,
  parameter logic [BITS-1:0] IMASK_BASE = DEF_IMASK_BASE,
  parameter logic [BITS-1:0] ICTRL_BASE = DEF_ICTRL_BASE
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            we,
  input  logic [BITS-1:0] memAddr,
  input  logic [BITS-1:0] dataBusIn,
  output logic [BITS-1:0] dataBusOut,
  input  logic [NSRC-1:0] irqIn,
  output logic            intrReq,
  output logic [3:0]      intrId,
  input  logic            intrAck,
  input  logic            intrDone
);

  logic [NSRC-1:0] irq_prev_q;
  logic [NSRC-1:0] ipend_q;
  logic [NSRC-1:0] ipend_d;
  logic [NSRC-1:0] imask_q;
  logic [NSRC-1:0] event_s;
  logic [NSRC-1:0] cand_s;
  logic [NSRC-1:0] w1c_s;
  logic [NSRC-1:0] ack_clr_s;
  logic            gie_q;
  irq_state_e      state_q;
  logic            intr_req_q;
  logic [ID_W-1:0] intr_id_q;
  logic [ID_W-1:0] win_id_s;
  logic            win_valid_s;
  logic            wr_ipend_s;
  logic            wr_imask_s;
  logic            wr_ictrl_s;
  logic            ack_ok_s;
  logic [BITS-1:0] ictrl_s;
  logic [BITS-1:0] rdata_s;
  logic            unused_s;

  assign unused_s   = ^dataBusIn[BITS-1:NSRC];
  assign wr_ipend_s = we & (memAddr == IPEND_BASE);
  assign wr_imask_s = we & (memAddr == IMASK_BASE);
  assign wr_ictrl_s = we & (memAddr == ICTRL_BASE);
  assign ack_ok_s   = (state_q == ST_REQ) & intrAck;
  assign event_s    = irqIn & ~irq_prev_q;
  assign cand_s     = ipend_q & imask_q;

  Register #(.WIDTH(NSRC)) u_imask (
    .clk   (clk),
    .reset (reset),
    .load  (wr_imask_s),
    .d     (dataBusIn[NSRC-1:0]),
    .q     (imask_q)
  );

  Register #(.WIDTH(1)) u_gie (
    .clk   (clk),
    .reset (reset),
    .load  (wr_ictrl_s),
    .d     (dataBusIn[ICTRL_GIE]),
    .q     (gie_q)
  );

  irq_prio_enc #(.NSRC(NSRC), .ID_W(ID_W)) u_prio (
    .req   (cand_s),
    .valid (win_valid_s),
    .idx   (win_id_s)
  );

  // pending update: clears first, then new events, so a same-cycle set wins
  always_comb begin
    w1c_s     = wr_ipend_s ? dataBusIn[NSRC-1:0] : {NSRC{1'b0}};
    ack_clr_s = {NSRC{1'b0}};
    for (int i = 0; i < NSRC; i++) begin
      ack_clr_s[i] = ack_ok_s & (intr_id_q == ID_W'(i));
    end
    ipend_d = (ipend_q & ~w1c_s & ~ack_clr_s) | event_s;
  end

  // edge-detect history and pending latch
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_prev_q <= {NSRC{1'b0}};
      ipend_q    <= {NSRC{1'b0}};
    end else begin
      irq_prev_q <= irqIn;
      ipend_q    <= ipend_d;
    end
  end

  // request/acknowledge/done handshake; GIE is the registered value
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      intr_req_q <= 1'b0;
      intr_id_q  <= {ID_W{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (gie_q && win_valid_s) begin
            state_q    <= ST_REQ;
            intr_req_q <= 1'b1;
            intr_id_q  <= win_id_s;
          end
        end
        ST_REQ: begin
          if (intrAck) begin
            state_q    <= ST_SERVICE;
            intr_req_q <= 1'b0;
          end else if (!gie_q) begin
            state_q    <= ST_IDLE;
            intr_req_q <= 1'b0;
          end
        end
        ST_SERVICE: begin
          if (intrDone) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          intr_req_q <= 1'b0;
        end
      endcase
    end
  end

  // combinational register read mux
  always_comb begin
    ictrl_s                            = {BITS{1'b0}};
    ictrl_s[ICTRL_GIE]                 = gie_q;
    ictrl_s[ICTRL_BUSY]                = (state_q != ST_IDLE);
    ictrl_s[ICTRL_ID_MSB:ICTRL_ID_LSB] = intr_id_q;
    rdata_s                            = {BITS{1'b0}};
    if (we) begin
      rdata_s = {BITS{1'b0}};
    end else begin
      case (memAddr)
        IPEND_BASE: rdata_s = BITS'(ipend_q);
        IMASK_BASE: rdata_s = BITS'(imask_q);
        ICTRL_BASE: rdata_s = ictrl_s;
        default:    rdata_s = {BITS{1'b0}};
      endcase
    end
  end

  assign dataBusOut = rdata_s;
  assign intrReq    = intr_req_q;
  assign intrId     = intr_id_q;

endmodule
